// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: slow_clk ticks drive the count down, and a single
// pushbutton starts, pauses, resumes and acknowledges the timer.
module countdown_timer #(
   parameter int unsigned TICKS_PER_STEP = 2
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       slow_clk,
   input  logic       start_n,
   input  logic [7:0] preset,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic [9:0] LEDR
);

   localparam int unsigned STEP_W = 8;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t            state, state_d;
   logic [7:0]        count, count_d, count_dec;
   logic [STEP_W-1:0] step, step_d;
   logic              slow_q;
   logic              start_s1, start_s2, start_h;
   logic              tick_c, press_c;

   // Limit each BCD digit to 9.
   function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
      logic [3:0] t, o;
      t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
      return {t, o};
   endfunction

   // Decrement by one BCD unit; 00 stays 00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h00)
         r = 8'h00;
      else if (v[3:0] == 4'd0)
         r = {v[7:4] - 4'd1, 4'd9};
      else
         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Tick edge detect and pushbutton synchronizer with history flop.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         slow_q   <= 1'b0;
         start_s1 <= 1'b1;
         start_s2 <= 1'b1;
         start_h  <= 1'b1;
      end else begin
         slow_q   <= slow_clk;
         start_s1 <= start_n;
         start_s2 <= start_s1;
         start_h  <= start_s2;
      end
   end

   assign tick_c    = slow_clk & ~slow_q;
   assign press_c   = start_h & ~start_s2;
   assign count_dec = bcd_dec(count);

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state <= IDLE;
         count <= 8'h00;
         step  <= '0;
      end else begin
         state <= state_d;
         count <= count_d;
         step  <= step_d;
      end
   end

   always_comb begin
      state_d = state;
      count_d = count;
      step_d  = step;
      case (state)
         IDLE: begin
            count_d = bcd_clamp(preset);
            if (press_c) begin
               count_d = count;
               step_d  = '0;
               state_d = (count == 8'h00) ? DONE : RUN;
            end
         end
         RUN: begin
            // A press in the same cycle as a tick pauses and drops the tick.
            if (press_c) begin
               state_d = PAUSE;
            end else if (tick_c) begin
               if (step == STEP_LAST) begin
                  step_d  = '0;
                  count_d = count_dec;
                  if (count_dec == 8'h00)
                     state_d = DONE;
               end else begin
                  step_d = step + STEP_W'(1);
               end
            end
         end
         PAUSE: begin
            if (press_c)
               state_d = RUN;
         end
         DONE: begin
            count_d = 8'h00;
            if (press_c)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign HEX1 = seg7(count[7:4]);
   assign HEX0 = seg7(count[3:0]);
   assign LEDR = {state == RUN, state == PAUSE, state == DONE,
                  ((state == DONE) && slow_q) ? 7'h7F : 7'h00};

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized stimulus against a
// decimal reference model of the timer.
module tb_countdown_timer;

   localparam int TPS = 2;
   localparam int MI = 0, MR = 1, MP = 2, MD = 3;

   logic       clk_in = 1'b0;
   logic       reset_n, slow_clk, start_n;
   logic [7:0] preset;
   logic [6:0] HEX1, HEX0;
   logic [9:0] LEDR;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: count kept as a plain decimal number.
   int m_mode = MI;
   int m_cnt  = 0;
   int m_stp  = 0;
   bit m_slow_prev = 1'b0;
   bit m_p0 = 1'b1, m_p1 = 1'b1, m_p2 = 1'b1;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   countdown_timer #(.TICKS_PER_STEP(TPS)) dut (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .slow_clk(slow_clk),
      .start_n (start_n),
      .preset  (preset),
      .HEX1    (HEX1),
      .HEX0    (HEX0),
      .LEDR    (LEDR)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic int clamp_preset();
      int t, o;
      t = int'(preset[7:4]);
      o = int'(preset[3:0]);
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      return t * 10 + o;
   endfunction

   task automatic model_update();
      bit tick, ev;
      if (!reset_n) begin
         m_mode = MI; m_cnt = 0; m_stp = 0; m_slow_prev = 1'b0;
         m_p0 = 1'b1; m_p1 = 1'b1; m_p2 = 1'b1;
         return;
      end
      tick = slow_clk && !m_slow_prev;
      ev   = m_p2 && !m_p1;
      case (m_mode)
         MI: if (ev) begin m_mode = (m_cnt == 0) ? MD : MR; m_stp = 0; end
             else m_cnt = clamp_preset();
         MR: if (ev) m_mode = MP;
             else if (tick) begin
                m_stp++;
                if (m_stp == TPS) begin
                   m_stp = 0;
                   m_cnt--;
                   if (m_cnt == 0) m_mode = MD;
                end
             end
         MP: if (ev) m_mode = MR;
         default: if (ev) m_mode = MI;
      endcase
      m_p2 = m_p1; m_p1 = m_p0; m_p0 = start_n;
      m_slow_prev = slow_clk;
   endtask

   function automatic logic [23:0] exp_out();
      logic [9:0] led;
      led = '0;
      if (m_mode == MR) led[9] = 1'b1;
      if (m_mode == MP) led[8] = 1'b1;
      if (m_mode == MD) begin
         led[7] = 1'b1;
         if (m_slow_prev) led[6:0] = 7'h7F;
      end
      return {seg_tab[m_cnt / 10], seg_tab[m_cnt % 10], led};
   endfunction

   task automatic cyc();
      @(posedge clk_in);
      model_update();
      @(negedge clk_in);
   endtask

   task automatic press();
      start_n = 1'b0;
      repeat (4) cyc();
      start_n = 1'b1;
      repeat (4) cyc();
   endtask

   task automatic tick_once();
      slow_clk = 1'b1;
      repeat (2) cyc();
      slow_clk = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start_n = 1'b1; slow_clk = 1'b0;
      cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_n = 1'b1; slow_clk = 1'b1; preset = 8'h42;
      repeat (2) cyc();
      n_tests++; if (HEX1 !== 7'h40) begin n_fail++; $display("FAIL reset_hex1 got=%h exp=40", HEX1); end
      n_tests++; if (HEX0 !== 7'h40) begin n_fail++; $display("FAIL reset_hex0 got=%h exp=40", HEX0); end
      n_tests++; if (LEDR !== 10'h000) begin n_fail++; $display("FAIL reset_ledr got=%h exp=000", LEDR); end
      // Button held through reset: nothing in the first cycle, one event later.
      start_n = 1'b0; preset = 8'h05;
      cyc();
      reset_n = 1'b1;
      cyc();
      n_tests++; if (LEDR !== 10'h000) begin n_fail++; $display("FAIL reset_first_cycle LEDR got=%h exp=000", LEDR); end
      repeat (2) cyc();
      n_tests++; if (LEDR !== 10'h200) begin n_fail++; $display("FAIL reset_held_event LEDR got=%h exp=200", LEDR); end
      n_tests++; if ({HEX1, HEX0, LEDR} !== exp_out()) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", {HEX1, HEX0, LEDR}, exp_out()); end
      start_n = 1'b1;
      do_reset();
   endtask

   task automatic test_countdown();
      logic [6:0] exp_h0 [3] = '{7'h24, 7'h79, 7'h40};
      do_reset();
      preset = 8'h03;
      cyc();
      press();
      n_tests++; if (LEDR !== 10'h200) begin n_fail++; $display("FAIL cd_run LEDR got=%h exp=200", LEDR); end
      for (int k = 0; k < 3; k++) begin
         repeat (2) tick_once();
         n_tests++; if (HEX0 !== exp_h0[k]) begin n_fail++; $display("FAIL cd_step%0d HEX0 got=%h exp=%h", k, HEX0, exp_h0[k]); end
      end
      n_tests++; if (LEDR !== 10'h080) begin n_fail++; $display("FAIL cd_done LEDR got=%h exp=080", LEDR); end
      n_tests++; if ({HEX1, HEX0, LEDR} !== exp_out()) begin n_fail++; $display("FAIL cd_model got=%h exp=%h", {HEX1, HEX0, LEDR}, exp_out()); end
   endtask

   task automatic test_borrow();
      do_reset();
      preset = 8'h10;
      cyc();
      press();
      repeat (2) tick_once();
      n_tests++; if (HEX1 !== 7'h40) begin n_fail++; $display("FAIL borrow HEX1 got=%h exp=40", HEX1); end
      n_tests++; if (HEX0 !== 7'h10) begin n_fail++; $display("FAIL borrow HEX0 got=%h exp=10", HEX0); end
      n_tests++; if (LEDR !== 10'h200) begin n_fail++; $display("FAIL borrow LEDR got=%h exp=200", LEDR); end
   endtask

   task automatic test_pause();
      do_reset();
      preset = 8'h06;
      cyc();
      press();
      repeat (3) tick_once();
      // Press event and tick land in the same cycle.
      start_n = 1'b0;
      repeat (2) cyc();
      slow_clk = 1'b1;
      repeat (2) cyc();
      start_n = 1'b1; slow_clk = 1'b0;
      repeat (4) cyc();
      n_tests++; if (LEDR !== 10'h100) begin n_fail++; $display("FAIL pause_state LEDR got=%h exp=100", LEDR); end
      n_tests++; if (HEX0 !== 7'h12) begin n_fail++; $display("FAIL pause_count HEX0 got=%h exp=12", HEX0); end
      repeat (10) tick_once();
      n_tests++; if (HEX0 !== 7'h12 || LEDR !== 10'h100) begin n_fail++; $display("FAIL pause_hold HEX0=%h LEDR=%h exp 12/100", HEX0, LEDR); end
      press();
      tick_once();
      n_tests++; if (HEX0 !== 7'h19) begin n_fail++; $display("FAIL pause_resume HEX0 got=%h exp=19", HEX0); end
      n_tests++; if ({HEX1, HEX0, LEDR} !== exp_out()) begin n_fail++; $display("FAIL pause_model got=%h exp=%h", {HEX1, HEX0, LEDR}, exp_out()); end
   endtask

   task automatic test_zero_preset();
      do_reset();
      preset = 8'h00;
      cyc();
      press();
      n_tests++; if (LEDR !== 10'h080) begin n_fail++; $display("FAIL zero_done LEDR got=%h exp=080", LEDR); end
      slow_clk = 1'b1;
      repeat (2) cyc();
      n_tests++; if (LEDR !== 10'h0FF) begin n_fail++; $display("FAIL zero_flash_on LEDR got=%h exp=0ff", LEDR); end
      slow_clk = 1'b0;
      repeat (2) cyc();
      n_tests++; if (LEDR !== 10'h080) begin n_fail++; $display("FAIL zero_flash_off LEDR got=%h exp=080", LEDR); end
      press();
      n_tests++; if (LEDR !== 10'h000) begin n_fail++; $display("FAIL zero_ack LEDR got=%h exp=000", LEDR); end
   endtask

   task automatic test_hold_button();
      do_reset();
      preset = 8'hFA;
      cyc();
      n_tests++; if (HEX1 !== 7'h10 || HEX0 !== 7'h10) begin n_fail++; $display("FAIL clamp HEX1=%h HEX0=%h exp 10/10", HEX1, HEX0); end
      start_n = 1'b0;
      repeat (50) cyc();
      n_tests++; if (LEDR !== 10'h200) begin n_fail++; $display("FAIL hold_low LEDR got=%h exp=200", LEDR); end
      start_n = 1'b1;
      repeat (4) cyc();
      n_tests++; if (LEDR !== 10'h200) begin n_fail++; $display("FAIL hold_release LEDR got=%h exp=200", LEDR); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      preset = 8'h37;
      cyc();
      press();
      preset = 8'h99;
      repeat (3) cyc();
      n_tests++; if (HEX1 !== 7'h30 || HEX0 !== 7'h78 || LEDR !== 10'h200)
         begin n_fail++; $display("FAIL run37 HEX1=%h HEX0=%h LEDR=%h exp 30/78/200", HEX1, HEX0, LEDR); end
      reset_n = 1'b0;
      cyc();
      n_tests++; if (HEX1 !== 7'h40 || HEX0 !== 7'h40 || LEDR !== 10'h000)
         begin n_fail++; $display("FAIL midrun_reset HEX1=%h HEX0=%h LEDR=%h exp 40/40/000", HEX1, HEX0, LEDR); end
      reset_n = 1'b1;
      cyc();
      n_tests++; if (HEX1 !== 7'h10 || HEX0 !== 7'h10 || LEDR !== 10'h000)
         begin n_fail++; $display("FAIL after_reset_load HEX1=%h HEX0=%h LEDR=%h exp 10/10/000", HEX1, HEX0, LEDR); end
   endtask

   task automatic test_random();
      int hold = 0;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         reset_n = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
         if (hold == 0) begin
            start_n = ~start_n;
            hold = $urandom_range(1, 40);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 59) == 0)
            preset = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         cyc();
         n_tests++;
         if ({HEX1, HEX0, LEDR} !== exp_out()) begin
            n_fail++;
            $display("FAIL random cycle %0d got=%h exp=%h", i, {HEX1, HEX0, LEDR}, exp_out());
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; slow_clk = 1'b0; start_n = 1'b1; preset = 8'h00;
      test_reset();
      test_countdown();
      test_borrow();
      test_pause();
      test_zero_preset();
      test_hold_button();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICKS_PER_STEP, default 2: rising edges of slow_clk per one-count decrement, legal range 1..255.
REQ-002 clk_in  input  1  sole system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 slow_clk  input  1  square wave from the upstream clock divider, same clock domain; each 0->1 transition is one tick.
REQ-005 start_n  input  1  active-low pushbutton (asynchronous); each press is one start/pause/acknowledge event.
REQ-006 preset  input  8  start value as two BCD digits: tens [7:4], ones [3:0].
REQ-007 HEX1  output  7  tens digit, active-low segments {g,f,e,d,c,b,a}.
REQ-008 HEX0  output  7  ones digit, same encoding.
REQ-009 LEDR  output  10  status: [9]=RUN, [8]=PAUSE, [7]=DONE, [6:0]=done flash.

Function
REQ-010 slow_clk shall be registered once (slow_q); a tick is the cycle where slow_clk=1 and slow_q=0.
REQ-011 start_n shall pass through a 2-flop synchronizer plus one history flop; a press event is a synchronized 1->0 transition, one cycle wide.
REQ-012 Holding start_n low shall generate exactly one event; no further event until released and pressed again.
REQ-013 FSM states: IDLE, RUN, PAUSE, DONE; exactly one state active.
REQ-014 IDLE: count loads clamped preset every cycle; a digit >9 is clamped to 9 (preset 8'hAF -> 99).
REQ-015 IDLE + press: count != 00 -> RUN with step counter cleared to 0; count == 00 -> DONE.
REQ-016 RUN: each tick increments step counter; on the tick that brings it to TICKS_PER_STEP, count decrements by one BCD unit and step counter clears.
REQ-017 BCD decrement: ones 0 -> 9 with tens decremented; otherwise ones-1; tens never underflows.
REQ-018 RUN: when count becomes 00, state shall be DONE in the same clk_in edge that writes 00.
REQ-019 RUN + press -> PAUSE; when press and tick coincide, press wins and the tick is discarded (no step, no decrement).
REQ-020 PAUSE: count and step counter hold; ticks ignored; press -> RUN, resuming from the retained step count.
REQ-021 DONE: count holds 00; LEDR[6:0] = 7'h7F while slow_q=1, else 7'h00; press -> IDLE.
REQ-022 Latency: count/state updates appear on the clk_in edge immediately after the tick or press-event cycle.
REQ-023 HEX decode shall be combinational from count: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-024 LEDR[9:7] shall be one-hot decode of RUN/PAUSE/DONE; all zero in IDLE.
REQ-025 preset changes outside IDLE shall have no effect.

Reset
REQ-026 reset_n=0 at a clk_in edge shall force: state IDLE, count 00, step counter 0, slow_q 0, synchronizer and history flops 1 (released).
REQ-027 Outputs after reset: HEX1=HEX0=7'h40, LEDR=10'h000.
REQ-028 Reset shall take priority over press events and ticks in any state, including mid-RUN and DONE.
REQ-029 No press event or tick shall be detected in the first cycle after reset_n rises, even if start_n is held low.

Verification
REQ-030 preset=8'h03, press, 6 ticks (TICKS_PER_STEP=2) -> count 02,01,00 after ticks 2,4,6; DONE with LEDR[7]=1 after tick 6; HEX0 shows 7'h40.
REQ-031 preset=8'h10, RUN, 2 ticks -> count 09 (HEX1=7'h40, HEX0=7'h10); BCD borrow verified.
REQ-032 RUN at count 05 with step=1, press coincident with tick -> PAUSE, count 05, step 1; 10 ticks -> unchanged; press, 1 tick -> count 04.
REQ-033 preset=8'h00, press -> DONE directly; LEDR[6:0] follows slow_q (7'h7F/7'h00); press -> IDLE, LEDR=0.
REQ-034 preset=8'hFA -> IDLE count 99 (HEX1=HEX0=7'h10); start_n held low 50 cycles -> exactly one event (RUN, not PAUSE).
REQ-035 reset_n=0 for one cycle mid-RUN at count 37 -> next cycle IDLE, HEX1=HEX0=7'h40, LEDR=0; after release count loads preset.
